// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranger: periodic trigger, echo-width to cm conversion, timeout/saturation.
// Optional median-of-three output filter enabled by defining ULTRASONIC_RANGER_MEDIAN_EN.
module ultrasonic_ranger #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned PV_WIDTH    = 9,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned PERIOD_MS   = 60,
  parameter int unsigned MAX_CM      = 400
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                echo,
  output logic                trig,
  output logic [PV_WIDTH-1:0] distance,
  output logic                sample_valid,
  output logic                timeout
);

  localparam int unsigned DIV        = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned TIMEOUT_US = MAX_CM * 58;
  localparam int unsigned PERIOD_US  = PERIOD_MS * 1000;
  localparam int unsigned US_MAX     = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int unsigned PRESC_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned US_W       = $clog2(US_MAX + 1);
  localparam int unsigned PER_W      = $clog2(PERIOD_US + 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;

  state_t               state, next_state;
  logic                 echo_s1, echo_sync, echo_prev;
  logic [PRESC_W-1:0]   presc;
  logic [US_W-1:0]      us_cnt;
  logic [PER_W-1:0]     per_cnt;
  logic [5:0]           sub_cnt;
  logic [PV_WIDTH-1:0]  cm_cnt;
  logic                 tick, echo_rise, echo_fall, cm_wrap, period_done, trig_entry;
  logic                 report, report_to;
  logic [PV_WIDTH-1:0]  report_cm, filtered;

  assign tick        = (presc == PRESC_W'(DIV - 1));
  assign echo_rise   = echo_sync & ~echo_prev;
  assign echo_fall   = ~echo_sync & echo_prev;
  assign cm_wrap     = tick && (sub_cnt == 6'd57);
  assign period_done = (per_cnt == PER_W'(PERIOD_US)) ||
                       (tick && (per_cnt == PER_W'(PERIOD_US - 1)));
  assign trig_entry  = (next_state == TRIG) && (state != TRIG);

  always_comb begin
    next_state = state;
    report     = 1'b0;
    report_cm  = '0;
    report_to  = 1'b0;
    if (!en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: next_state = TRIG;
        TRIG: if (tick && (us_cnt == US_W'(TRIG_US - 1))) next_state = WAIT_ECHO;
        WAIT_ECHO: begin
          if (echo_rise) begin
            next_state = MEASURE;
          end else if (tick && (us_cnt == US_W'(TIMEOUT_US - 1))) begin
            report     = 1'b1;
            report_cm  = PV_WIDTH'(MAX_CM);
            report_to  = 1'b1;
            next_state = HOLDOFF;
          end
        end
        MEASURE: begin
          if (echo_fall) begin
            report     = 1'b1;
            report_cm  = cm_cnt;
            next_state = HOLDOFF;
          end else if (cm_wrap && (cm_cnt == PV_WIDTH'(MAX_CM - 1))) begin
            report     = 1'b1;
            report_cm  = PV_WIDTH'(MAX_CM);
            report_to  = 1'b1;
            next_state = HOLDOFF;
          end
        end
        // A saturated echo may still be high here; never retrigger into it.
        HOLDOFF: if (period_done && !echo_sync) next_state = TRIG;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      echo_s1      <= 1'b0;
      echo_sync    <= 1'b0;
      echo_prev    <= 1'b0;
      presc        <= '0;
      us_cnt       <= '0;
      per_cnt      <= '0;
      sub_cnt      <= '0;
      cm_cnt       <= '0;
      trig         <= 1'b0;
      distance     <= '0;
      sample_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state     <= next_state;
      echo_s1   <= echo;
      echo_sync <= echo_s1;
      echo_prev <= echo_sync;
      trig      <= (next_state == TRIG);

      if (trig_entry || tick) presc <= '0;
      else                    presc <= presc + 1'b1;

      if (next_state != state)                                 us_cnt <= '0;
      else if (tick && (state == TRIG || state == WAIT_ECHO))  us_cnt <= us_cnt + 1'b1;

      if (trig_entry)                                     per_cnt <= '0;
      else if (tick && (per_cnt != PER_W'(PERIOD_US)))    per_cnt <= per_cnt + 1'b1;

      if (state != MEASURE) begin
        sub_cnt <= '0;
        cm_cnt  <= '0;
      end else if (cm_wrap) begin
        sub_cnt <= '0;
        cm_cnt  <= cm_cnt + 1'b1;
      end else if (tick) begin
        sub_cnt <= sub_cnt + 1'b1;
      end

      sample_valid <= report;
      if (report) begin
        distance <= filtered;
        timeout  <= report_to;
      end
    end
  end

`ifdef ULTRASONIC_RANGER_MEDIAN_EN
  logic [PV_WIDTH-1:0] hist1, hist2;
  logic                primed;

  function automatic logic [PV_WIDTH-1:0] median3(input logic [PV_WIDTH-1:0] a,
                                                   input logic [PV_WIDTH-1:0] b,
                                                   input logic [PV_WIDTH-1:0] c);
    logic [PV_WIDTH-1:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  // Until primed, the window is treated as three copies of the incoming sample.
  assign filtered = primed ? median3(report_cm, hist1, hist2) : report_cm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist1  <= '0;
      hist2  <= '0;
      primed <= 1'b0;
    end else if (!en) begin
      primed <= 1'b0;
    end else if (report) begin
      hist1  <= report_cm;
      hist2  <= primed ? hist1 : report_cm;
      primed <= 1'b1;
    end
  end
`else
  assign filtered = report_cm;
`endif

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger with scaled-down timing parameters.
// Checks every cycle against an event-level model of samples plus literal scenario pins.
module tb_ultrasonic_ranger;

  localparam int CLK_HZ     = 2_000_000;
  localparam int DIV        = CLK_HZ / 1_000_000;
  localparam int TRIG_US    = 10;
  localparam int PERIOD_MS  = 2;
  localparam int MAX_CM     = 20;
  localparam int TRIG_CYC   = TRIG_US * DIV;
  localparam int PERIOD_CYC = PERIOD_MS * 1000 * DIV;
  localparam int K_NORM = 0, K_SAT = 1, K_NONE = 2;

  logic       clk = 1'b0;
  logic       reset, en, echo;
  logic       trig, sample_valid, timeout;
  logic [8:0] distance;

  ultrasonic_ranger #(
    .CLK_FREQ_HZ(CLK_HZ),
    .PV_WIDTH   (9),
    .TRIG_US    (TRIG_US),
    .PERIOD_MS  (PERIOD_MS),
    .MAX_CM     (MAX_CM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .echo        (echo),
    .trig        (trig),
    .distance    (distance),
    .sample_valid(sample_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {int cm; bit to;} exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, rise_cyc = 0, sv_count = 0;
  int exp_dist = 0, exp_to = 0, last_dist = 0, last_to = 0;
  bit m_primed = 0;
  int h1 = 0, h2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model of the sample stream: raw sample, optionally median-filtered over the last three.
  function automatic int filt(input int raw);
`ifdef ULTRASONIC_RANGER_MEDIAN_EN
    int mx, mn, r;
    if (!m_primed) begin
      h1 = raw; h2 = raw; m_primed = 1;
      return raw;
    end
    mx = (raw > h1) ? raw : h1; mx = (mx > h2) ? mx : h2;
    mn = (raw < h1) ? raw : h1; mn = (mn < h2) ? mn : h2;
    r  = raw + h1 + h2 - mx - mn;
    h2 = h1; h1 = raw;
    return r;
`else
    return raw;
`endif
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      check("rst_trig", int'(trig), 0);
      check("rst_dist", int'(distance), 0);
      check("rst_sv", int'(sample_valid), 0);
      check("rst_to", int'(timeout), 0);
    end else if (sample_valid) begin
      sv_count++;
      last_dist = int'(distance);
      last_to   = int'(timeout);
      if (exp_q.size() == 0) begin
        check("unexpected_sv", 1, 0);
        exp_dist = last_dist;
        exp_to   = last_to;
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        exp_dist = filt(e.cm);
        exp_to   = int'(e.to);
        check("sample_dist", last_dist, exp_dist);
        check("sample_to", last_to, exp_to);
      end
    end else begin
      check("hold_dist", int'(distance), exp_dist);
      check("hold_to", int'(timeout), exp_to);
    end
  end

  task automatic wait_rise(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (trig) begin
        ok = 1;
        rise_cyc = cyc;
        break;
      end
    end
    if (!ok) check("trig_rise_timeout", 0, 1);
  endtask

  task automatic wait_fall(output int w);
    w = 0;
    while (trig && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
  endtask

  // Entered just after a trig rise; returns just after the following trig rise.
  task automatic run_meas(input int kind, input int delay_us, input int width_us,
                          input bit chk_period, input int lit_dist, input int lit_to);
    int w, sv0, prev_rise;
    bit ok;
    exp_t e;
    prev_rise = rise_cyc;
    sv0 = sv_count;
    wait_fall(w);
    check("trig_width", w, TRIG_CYC);
    if (kind == K_NORM) begin e.cm = width_us / 58; e.to = 0; end
    else begin e.cm = MAX_CM; e.to = 1; end
    exp_q.push_back(e);
    if (kind != K_NONE) begin
      repeat (delay_us * DIV) @(posedge clk);
      #1 echo = 1'b1;
      repeat (width_us * DIV) @(posedge clk);
      #1;
      if (kind == K_SAT) check("sv_before_fall", sv_count - sv0, 1);
      echo = 1'b0;
    end
    wait_rise(PERIOD_CYC + 2000, ok);
    if (ok && chk_period) check("period", rise_cyc - prev_rise, PERIOD_CYC);
    check("sv_once", sv_count - sv0, 1);
    if (lit_dist >= 0) begin
      check("lit_dist", last_dist, lit_dist);
      check("lit_to", last_to, lit_to);
    end
  endtask

  task automatic en_drop_test();
    int w, sv0;
    bit ok;
    sv0 = sv_count;
    wait_fall(w);
    repeat (50 * DIV) @(posedge clk);
    #1 echo = 1'b1;
    repeat (200 * DIV) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk); #1;
    check("en_drop_trig", int'(trig), 0);
    echo = 1'b0;
    m_primed = 0;
    repeat (50) @(posedge clk);
    #1;
    check("en_drop_trig_low", int'(trig), 0);
    check("en_drop_no_sv", sv_count - sv0, 0);
    check("en_drop_dist_held", int'(distance), exp_dist);
    en = 1'b1;
    w = 0; ok = 0;
    while (!ok && w < 5) begin
      @(posedge clk); #1;
      w++;
      if (trig) ok = 1;
    end
    rise_cyc = cyc;
    check("en_rise_within_2", int'(ok && w <= 2), 1);
  endtask

  task automatic reset_test();
    int w;
    bit ok;
    wait_fall(w);
    repeat (50 * DIV) @(posedge clk);
    #1 echo = 1'b1;
    repeat (200 * DIV) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_trig", int'(trig), 0);
    check("rst_mid_dist", int'(distance), 0);
    check("rst_mid_sv", int'(sample_valid), 0);
    check("rst_mid_to", int'(timeout), 0);
    exp_dist = 0; exp_to = 0;
    exp_q.delete();
    m_primed = 0;
    echo = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_rise(5, ok);
  endtask

  initial begin
    bit ok;
    int kind, cm, dly, wid;
    reset = 1'b1; en = 1'b0; echo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_trig", int'(trig), 0);
    check("init_dist", int'(distance), 0);
    check("init_to", int'(timeout), 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_en_low_trig", int'(trig), 0);
    en = 1'b1;
    wait_rise(5, ok);

    run_meas(K_NORM, 100, 580, 1'b0, 10, 0);
    run_meas(K_SAT, 100, 1300, 1'b1, MAX_CM, 1);
    run_meas(K_NONE, 0, 0, 1'b1, MAX_CM, 1);
    en_drop_test();
`ifdef ULTRASONIC_RANGER_MEDIAN_EN
    run_meas(K_NORM, 40, 10 * 58 + 29, 1'b0, 10, 0);
    run_meas(K_NORM, 40, 18 * 58 + 29, 1'b1, 10, 0);
    run_meas(K_NORM, 40, 12 * 58 + 29, 1'b1, 12, 0);
`else
    run_meas(K_NORM, 40, 10 * 58 + 29, 1'b0, 10, 0);
    run_meas(K_NORM, 40, 18 * 58 + 29, 1'b1, 18, 0);
    run_meas(K_NORM, 40, 12 * 58 + 29, 1'b1, 12, 0);
`endif

    for (int i = 0; i < 6; i++) begin
      kind = int'($urandom_range(2, 0));
      dly  = int'($urandom_range(300, 5));
      if (kind == K_NORM) begin
        cm  = int'($urandom_range(MAX_CM - 1, 0));
        wid = cm * 58 + int'($urandom_range(54, 3));
      end else begin
        wid = int'($urandom_range(1300, MAX_CM * 58 + 5));
      end
      run_meas(kind, dly, wid, 1'b1, -1, 0);
    end

    reset_test();
    run_meas(K_NORM, 60, 7 * 58 + 20, 1'b0, 7, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
